// File: rtl/bus_resp_collector.sv
// Single-outstanding bus response collector: decodes req_addr[31:28] to RAM/UART/GPIO, waits for the
// selected slave strobe and returns one registered response. Define BUS_TIMEOUT_EN to add a WAIT timeout.
module bus_resp_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic        rdy_ram,
    input  logic        rdy_uart,
    input  logic        rdy_gpio,
    input  logic [31:0] rdata_ram,
    input  logic [31:0] rdata_uart,
    input  logic [31:0] rdata_gpio,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] REG_RAM  = 4'h1;
    localparam logic [3:0] REG_UART = 4'h2;
    localparam logic [3:0] REG_GPIO = 4'h3;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..1023");
    end

    state_e      state_q;
    logic [3:0]  region_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        sel_rdy;
    logic [31:0] sel_rdata;
    logic        req_mapped;
    logic        unused_addr;

    assign unused_addr = ^req_addr[27:0];
    assign req_mapped  = (req_addr[31:28] == REG_RAM) || (req_addr[31:28] == REG_UART) ||
                         (req_addr[31:28] == REG_GPIO);

    // Only the latched slave is observed; other strobes never reach the FSM.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_rdata = '0;
        case (region_q)
            REG_RAM:  begin sel_rdy = rdy_ram;  sel_rdata = rdata_ram;  end
            REG_UART: begin sel_rdy = rdy_uart; sel_rdata = rdata_uart; end
            REG_GPIO: begin sel_rdy = rdy_gpio; sel_rdata = rdata_gpio; end
            default:  begin sel_rdy = 1'b0;     sel_rdata = '0;         end
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            region_q <= 4'h0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        region_q <= req_addr[31:28];
                        we_q     <= req_we;
`ifdef BUS_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                        if (req_mapped) begin
                            state_q <= WAIT;
                        end else begin
                            state_q <= RESP;
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // A strobe in the limit cycle still completes normally.
                    if (sel_rdy) begin
                        state_q <= RESP;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : sel_rdata;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        state_q <= RESP;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_bus_resp_collector.sv
// Randomized scoreboard bench for bus_resp_collector: the driver pushes the expected response per
// transaction (cycle, data, error) and an independent monitor pops and checks each response.
module tb_bus_resp_collector;

`ifdef BUS_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0;
    logic        rdy_ram = 1'b0, rdy_uart = 1'b0, rdy_gpio = 1'b0;
    logic [31:0] rdata_ram = '0, rdata_uart = '0, rdata_gpio = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    bus_resp_collector #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .rdy_ram(rdy_ram), .rdy_uart(rdy_uart), .rdy_gpio(rdy_gpio),
        .rdata_ram(rdata_ram), .rdata_uart(rdata_uart), .rdata_gpio(rdata_gpio),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        int          d;
        logic [31:0] data;
        int          bp;
        bit          pre;
    } txn_t;

    typedef struct {
        int          start;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    txn_t txns[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_acc = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int slave_of(input logic [31:0] a);
        int r;
        r = int'(a[31:28]);
        return (r >= 1 && r <= 3) ? r : 0;
    endfunction

    // Monitor: pops one expectation per new response and checks it is held until accepted.
    initial begin
        bit   pending;
        exp_t cur;
        pending = 1'b0;
        cur = '{0, '0, 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
            end else if (resp_valid) begin
                chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
                if (!pending) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: rdata %h err %b at cycle %0d, expected none",
                                 resp_rdata, resp_err, cyc);
                        cur = '{cyc, resp_rdata, resp_err};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("resp_cycle", cyc, cur.start);
                        chk("resp_rdata", resp_rdata, cur.rdata);
                        chk("resp_err", {31'b0, resp_err}, {31'b0, cur.err});
                    end
                end else begin
                    chk("hold_rdata", resp_rdata, cur.rdata);
                    chk("hold_err", {31'b0, resp_err}, {31'b0, cur.err});
                end
                pending = !resp_ready;
            end
        end
    end

    task automatic raise_req(input txn_t t);
        req_valid = 1'b1;
        req_addr  = t.addr;
        req_we    = t.we;
    endtask

    task automatic clear_rdy();
        rdy_ram = 1'b0; rdy_uart = 1'b0; rdy_gpio = 1'b0;
    endtask

    // Random strobes on every slave except the selected one.
    task automatic drive_noise(input int sel);
        rdy_ram  = (sel != 1) && ($urandom_range(0, 1) == 1);
        rdy_uart = (sel != 2) && ($urandom_range(0, 1) == 1);
        rdy_gpio = (sel != 3) && ($urandom_range(0, 1) == 1);
        rdata_ram = $urandom; rdata_uart = $urandom; rdata_gpio = $urandom;
    endtask

    task automatic do_txn(input txn_t t, input bit has_next, input txn_t nxt);
        int   a, h, n, sel, g;
        bit   rr, to_hit, early;
        exp_t e;
        resp_ready = (t.bp == 0);
        // Accept: every slave strobes while IDLE, all of which must be ignored.
        n = 0;
        do begin
            rr = req_ready;
            rdy_ram = 1'b1; rdy_uart = 1'b1; rdy_gpio = 1'b1;
            rdata_ram = $urandom; rdata_uart = $urandom; rdata_gpio = $urandom;
            @(posedge clk); #1;
            n++;
        end while (!rr && n < 50);
        a = cyc;
        clear_rdy();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_we    = 1'($urandom);
        if (!rr) chk("accept_timeout", 32'd0, 32'd1);
        if (exp_acc >= 0) chk("accept_cycle", a, exp_acc);

        sel    = slave_of(t.addr);
        to_hit = TO_EN && (sel != 0) && (t.d >= TO);
        e.start = (sel == 0) ? a : (to_hit ? a + TO : a + t.d + 1);
        e.err   = (sel == 0) || to_hit;
        e.rdata = (e.err || t.we) ? 32'h0 : t.data;
        exp_q.push_back(e);

        early = has_next && nxt.pre;
        if (early) raise_req(nxt);

        if (sel != 0) begin
            repeat (to_hit ? TO : t.d) begin
                drive_noise(sel);
                @(posedge clk); #1;
            end
            if (!to_hit) begin
                drive_noise(sel);
                case (sel)
                    1: begin rdy_ram  = 1'b1; rdata_ram  = t.data; end
                    2: begin rdy_uart = 1'b1; rdata_uart = t.data; end
                    default: begin rdy_gpio = 1'b1; rdata_gpio = t.data; end
                endcase
                @(posedge clk); #1;
            end
            clear_rdy();
        end

        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
        if (t.bp > 0) begin
            repeat (t.bp) @(posedge clk);
            #1;
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        h = cyc;
        chk("idle_after_hs", {30'b0, resp_valid, req_ready}, 32'd1);
        resp_ready = 1'($urandom);

        if (!has_next) begin
            exp_acc = -1;
        end else if (early) begin
            exp_acc = h + 1;
        end else begin
            g = $urandom_range(0, 2);
            repeat (g) begin @(posedge clk); #1; end
            raise_req(nxt);
            exp_acc = h + g + 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   rl[7];
        logic [3:0] r;
        txn_t t, dummy;
        int   a;
        rl = '{1, 2, 3, 0, 4, 7, 15};
        dummy = '{32'h0, 1'b0, 0, 32'h0, 0, 1'b0};

        txns.push_back('{32'h1000_0040, 1'b0, 2, 32'hCAFE_0001, 0, 1'b0});
        txns.push_back('{32'h3000_0000, 1'b1, 0, 32'h1234_5678, 0, 1'b0});
        txns.push_back('{32'h7000_0000, 1'b0, 0, 32'hDEAD_BEEF, 0, 1'b0});
        txns.push_back('{32'h2000_0010, 1'b0, 1, 32'h0BAD_F00D, 5, 1'b0});
        txns.push_back('{32'h1000_0100, 1'b0, 0, 32'h5555_AAAA, 0, 1'b1});
`ifdef BUS_TIMEOUT_EN
        txns.push_back('{32'h2000_0000, 1'b0, TO - 1, 32'h0000_0ACE, 0, 1'b0});
        txns.push_back('{32'h2000_0000, 1'b0, TO, 32'h0000_0BAD, 0, 1'b0});
`else
        txns.push_back('{32'h2000_0000, 1'b0, 1000, 32'h0000_0BAD, 0, 1'b0});
`endif
        for (int i = 0; i < 60; i++) begin
            r      = 4'(rl[$urandom_range(0, 6)]);
            t.addr = {r, 28'($urandom)};
            t.we   = 1'($urandom);
            t.d    = $urandom_range(0, 6);
            t.data = $urandom;
            t.bp   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            t.pre  = 1'($urandom);
            txns.push_back(t);
        end
        txns.push_back('{32'h1000_0000, 1'b0, 0, 32'hA5A5_5A5A, 0, 1'b0});

        // Reset state, then first accept on the first edge after release.
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        raise_req(txns[0]);
        @(negedge clk); #2;
        rst = 1'b0;
        exp_acc = cyc + 1;

        for (int i = 0; i < txns.size(); i++)
            do_txn(txns[i], i < txns.size() - 1, (i < txns.size() - 1) ? txns[i + 1] : dummy);

        // Reset in WAIT: transaction is dropped and a late RAM strobe must not produce a response.
        resp_ready = 1'b1;
        req_addr = 32'h1000_0000; req_we = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_req_ready", {31'b0, req_ready}, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("midrst_resp_rdata", resp_rdata, 32'd0);
        chk("midrst_resp_err", {31'b0, resp_err}, 32'd0);
        @(posedge clk); #1;
        rdy_ram = 1'b1; rdata_ram = 32'h7777_1111;
        req_addr = 32'h7000_0004; req_we = 1'b0; req_valid = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        a = cyc;
        exp_q.push_back('{a, 32'h0, 1'b1});
        req_valid = 1'b0;
        rdy_ram = 1'b0;
        chk("first_accept", {31'b0, req_ready}, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("post_rst_idle", {30'b0, resp_valid, req_ready}, 32'd1);
        repeat (5) begin @(posedge clk); #1; end
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
